// File: rtl/m_move_search_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// m_move_search_ctrl_pkg
// Shared board geometry, FSM state encoding and small index helpers for the
// Connect-Four move search slice (controller, drop-piece, evaluation).
// Board layout: bit r*FIELD_W+c is row r (0 = bottom), column c.
// Optional build macro used by the controller: SEARCH_CENTER_TIEBREAK_EN.
// ---------------------------------------------------------------------------
package m_move_search_ctrl_pkg;

    localparam int FIELD_W    = 7;
    localparam int FIELD_H    = 6;
    localparam int FIELD_SIZE = FIELD_W * FIELD_H;
    localparam int IDX_W      = $clog2(FIELD_SIZE);

    localparam logic [2:0] NO_COL     = 3'd7;
    localparam logic [2:0] CENTER_COL = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SET  = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } search_state_e;

    // Flat bit index of (row, col); callers keep row/col inside the board.
    function automatic logic [IDX_W-1:0] cell_idx(input int row, input int col);
        return IDX_W'(row * FIELD_W + col);
    endfunction

    // Distance of a column from the board centre.
    function automatic logic [2:0] center_dist(input logic [2:0] col);
        logic [2:0] d;
        if (col >= CENTER_COL) begin
            d = col - CENTER_COL;
        end else begin
            d = CENTER_COL - col;
        end
        return d;
    endfunction

endpackage

// File: rtl/m_evaluation_func.sv
// ---------------------------------------------------------------------------
// m_evaluation_func
// Combinational static board evaluation from the point of view of "me":
// each own stone +1, each horizontally adjacent own pair +8, and the same
// terms negated for the opponent.
//   i_me_field / i_op_field : stone fields, standard layout
//   o_score                 : signed score, SCORE_W bits
// ---------------------------------------------------------------------------
module m_evaluation_func
    import m_move_search_ctrl_pkg::*;
#(
    parameter int SCORE_W = 16
) (
    input  logic [FIELD_SIZE-1:0]     i_me_field,
    input  logic [FIELD_SIZE-1:0]     i_op_field,
    output logic signed [SCORE_W-1:0] o_score
);

    localparam logic signed [SCORE_W-1:0] STONE_WT = SCORE_W'(1);
    localparam logic signed [SCORE_W-1:0] PAIR_WT  = SCORE_W'(8);

    logic signed [SCORE_W-1:0] acc_s;

    // Accumulate stone and pair terms over the whole board.
    always_comb begin
        acc_s = '0;
        for (int r = 0; r < FIELD_H; r++) begin
            for (int c = 0; c < FIELD_W; c++) begin
                if (i_me_field[cell_idx(r, c)]) begin
                    acc_s = acc_s + STONE_WT;
                end else begin
                    acc_s = acc_s;
                end
                if (i_op_field[cell_idx(r, c)]) begin
                    acc_s = acc_s - STONE_WT;
                end else begin
                    acc_s = acc_s;
                end
            end
            for (int c = 0; c < FIELD_W - 1; c++) begin
                if (i_me_field[cell_idx(r, c)] && i_me_field[cell_idx(r, c + 1)]) begin
                    acc_s = acc_s + PAIR_WT;
                end else begin
                    acc_s = acc_s;
                end
                if (i_op_field[cell_idx(r, c)] && i_op_field[cell_idx(r, c + 1)]) begin
                    acc_s = acc_s - PAIR_WT;
                end else begin
                    acc_s = acc_s;
                end
            end
        end
        o_score = acc_s;
    end

endmodule

// File: rtl/m_move_search_ctrl_drop_piece.sv
// ---------------------------------------------------------------------------
// m_drop_piece
// Combinational gravity drop: sets the lowest empty cell of a column in the
// own field. Shared with the game-control FSM for human moves.
//   occ        : occupancy (me | op)
//   own_field  : stones of the player that drops
//   col        : target column 0..6 (7 yields an illegal, unchanged result)
//   cand_field : own_field plus the dropped stone
//   legal      : top cell of the column is empty
// ---------------------------------------------------------------------------
module m_drop_piece
    import m_move_search_ctrl_pkg::*;
(
    input  logic [FIELD_SIZE-1:0] occ,
    input  logic [FIELD_SIZE-1:0] own_field,
    input  logic [2:0]            col,
    output logic [FIELD_SIZE-1:0] cand_field,
    output logic                  legal
);

    logic placed_s;

    // Scan the column bottom-up and set the first empty cell.
    always_comb begin
        cand_field = own_field;
        legal      = 1'b0;
        placed_s   = 1'b0;
        if (col < 3'(FIELD_W)) begin
            legal = ~occ[cell_idx(FIELD_H - 1, int'(col))];
            for (int r = 0; r < FIELD_H; r++) begin
                if (!placed_s && !occ[cell_idx(r, int'(col))]) begin
                    cand_field[cell_idx(r, int'(col))] = 1'b1;
                    placed_s = 1'b1;
                end else begin
                    placed_s = placed_s;
                end
            end
        end else begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/m_move_search_ctrl.sv
// ---------------------------------------------------------------------------
// m_move_search_ctrl
// Greedy one-ply move search: on i_start snapshots both fields, drops "me"
// into each column in turn, evaluates every legal candidate and reports the
// best column. Fixed 15-cycle latency from the start edge to o_done.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_start           : start request, honoured only in IDLE
//   i_me_field        : own stones
//   i_op_field        : opponent stones
//   o_busy            : search in progress (SET/CMP)
//   o_done            : one-cycle result-valid pulse
//   o_valid_move      : a legal column existed
//   o_best_col        : chosen column, 7 if none
//   o_best_score      : score of the chosen column (most negative if none)
// Build macro SEARCH_CENTER_TIEBREAK_EN: equal scores prefer columns closer to
// the centre; otherwise the lowest column wins ties.
// ---------------------------------------------------------------------------
module m_move_search_ctrl
    import m_move_search_ctrl_pkg::*;
#(
    parameter int SCORE_W = 16,
    parameter int NCOL    = FIELD_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [FIELD_SIZE-1:0]     i_me_field,
    input  logic [FIELD_SIZE-1:0]     i_op_field,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_valid_move,
    output logic [2:0]                o_best_col,
    output logic signed [SCORE_W-1:0] o_best_score
);

    localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [2:0]                LAST_COL  = 3'(NCOL - 1);

    search_state_e             state_r, state_nx_s;
    logic [2:0]                col_r;
    logic [FIELD_SIZE-1:0]     me_snap_r, op_snap_r;
    logic [FIELD_SIZE-1:0]     eval_me_r, eval_op_r;
    logic                      legal_r;
    logic signed [SCORE_W-1:0] best_score_r;
    logic [2:0]                best_col_r;
    logic                      found_r;
    logic                      busy_r, done_r, valid_r;
    logic [2:0]                out_col_r;
    logic signed [SCORE_W-1:0] out_score_r;

    logic [FIELD_SIZE-1:0]     cand_s;
    logic                      legal_s;
    logic signed [SCORE_W-1:0] score_s;
    logic                      better_s;

    m_drop_piece u_drop (
        .occ        (me_snap_r | op_snap_r),
        .own_field  (me_snap_r),
        .col        (col_r),
        .cand_field (cand_s),
        .legal      (legal_s)
    );

    m_evaluation_func #(.SCORE_W(SCORE_W)) u_eval (
        .i_me_field (eval_me_r),
        .i_op_field (eval_op_r),
        .o_score    (score_s)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nx_s = ST_SET;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SET:  state_nx_s = ST_CMP;
            ST_CMP: begin
                if (col_r == LAST_COL) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SET;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Does the current candidate replace the running best?
    always_comb begin
        better_s = 1'b0;
        if (legal_r) begin
            if (!found_r) begin
                better_s = 1'b1;
            end else if (score_s > best_score_r) begin
                better_s = 1'b1;
`ifdef SEARCH_CENTER_TIEBREAK_EN
            end else if ((score_s == best_score_r) &&
                         (center_dist(col_r) < center_dist(best_col_r))) begin
                better_s = 1'b1;
`endif
            end else begin
                better_s = 1'b0;
            end
        end else begin
            better_s = 1'b0;
        end
    end

    // Search datapath and registered result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_r        <= 3'd0;
            me_snap_r    <= '0;
            op_snap_r    <= '0;
            eval_me_r    <= '0;
            eval_op_r    <= '0;
            legal_r      <= 1'b0;
            best_score_r <= SCORE_MIN;
            best_col_r   <= NO_COL;
            found_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            valid_r      <= 1'b0;
            out_col_r    <= NO_COL;
            out_score_r  <= '0;
        end else begin
            done_r <= 1'b0;
            busy_r <= (state_nx_s == ST_SET) || (state_nx_s == ST_CMP);
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        me_snap_r    <= i_me_field;
                        op_snap_r    <= i_op_field;
                        col_r        <= 3'd0;
                        best_score_r <= SCORE_MIN;
                        best_col_r   <= NO_COL;
                        found_r      <= 1'b0;
                    end
                end
                ST_SET: begin
                    eval_me_r <= cand_s;
                    eval_op_r <= op_snap_r;
                    legal_r   <= legal_s;
                end
                ST_CMP: begin
                    if (better_s) begin
                        best_score_r <= score_s;
                        best_col_r   <= col_r;
                        found_r      <= 1'b1;
                    end
                    if (col_r != LAST_COL) begin
                        col_r <= col_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    done_r      <= 1'b1;
                    valid_r     <= found_r;
                    out_col_r   <= found_r ? best_col_r : NO_COL;
                    out_score_r <= found_r ? best_score_r : SCORE_MIN;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_valid_move = valid_r;
    assign o_best_col   = out_col_r;
    assign o_best_score = out_score_r;

endmodule
